// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: coordinates, syncs, data-enable and pixel/line/frame
// strobes, as driven by vga_timing_gen and consumed by the pixel pipeline.
interface vga_timing_gen_if;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       pix_stb;
  logic       line_start;
  logic       frame_start;

  // Timing generator side
  modport master (
    output sx, sy, de, vga_hsync, vga_vsync, pix_stb, line_start, frame_start
  );

  // Downstream consumer side
  modport slave (
    input sx, sy, de, vga_hsync, vga_vsync, pix_stb, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator. Divides clk into a pixel strobe, walks sx/sy over
// the full H_TOTAL x V_TOTAL raster and produces registered de, syncs and
// line/frame start strobes aligned with the coordinates on the ports.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vid_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       HT_M1   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       VT_M1   = 10'(V_TOTAL - 1);

  // Window bounds carry an extra bit so an end bound of 1024 still fits.
  localparam logic [10:0] HA_END = 11'(H_ACTIVE);
  localparam logic [10:0] VA_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HPOL = (H_SYNC_POL != 0);
  localparam logic VPOL = (V_SYNC_POL != 0);

  // Reject configurations the counters cannot represent.
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be 1..1024");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       sx_q, sx_d;
  logic [9:0]       sy_q, sy_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             stb_q, stb_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic             adv;
  logic             h_wrap;
  logic             in_hs, in_vs, in_act;

  // Divider and raster advance: next coordinates, decoded from next values
  // so every registered output lines up with the registered sx/sy.
  always_comb begin
    adv    = (div_q == DIV_MAX);
    h_wrap = (sx_q == HT_M1);
    div_d  = adv ? '0 : div_q + 1'b1;
    sx_d   = sx_q;
    sy_d   = sy_q;
    if (adv) begin
      if (h_wrap) begin
        sx_d = '0;
        sy_d = (sy_q == VT_M1) ? '0 : sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end

    in_act = ({1'b0, sx_d} < HA_END) && ({1'b0, sy_d} < VA_END);
    in_hs  = ({1'b0, sx_d} >= HS_BEG) && ({1'b0, sx_d} < HS_END);
    in_vs  = ({1'b0, sy_d} >= VS_BEG) && ({1'b0, sy_d} < VS_END);

    // Decodes only move on an advance; between strobes everything holds.
    de_d  = adv ? in_act : de_q;
    hs_d  = adv ? (in_hs ? HPOL : ~HPOL) : hs_q;
    vs_d  = adv ? (in_vs ? VPOL : ~VPOL) : vs_q;
    stb_d = adv;
    ls_d  = adv && (sx_d == 10'd0);
    fs_d  = adv && (sx_d == 10'd0) && (sy_d == 10'd0);
  end

  // State and output registers; reset parks the raster on the last pixel so
  // the first advance lands on (0,0), and wins over any pending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      sx_q  <= HT_M1;
      sy_q  <= VT_M1;
      de_q  <= 1'b0;
      hs_q  <= ~HPOL;
      vs_q  <= ~VPOL;
      stb_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      stb_q <= stb_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign vid_o.sx          = sx_q;
  assign vid_o.sy          = sy_q;
  assign vid_o.de          = de_q;
  assign vid_o.vga_hsync   = hs_q;
  assign vid_o.vga_vsync   = vs_q;
  assign vid_o.pix_stb     = stb_q;
  assign vid_o.line_start  = ls_q;
  assign vid_o.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock: A uses the
// 640x480 defaults, B runs CLK_DIV=1 with positive hsync, C is a tiny raster
// (13x11, CLK_DIV=2) so whole frames and mid-frame reset fit in a short run.
// The stimulus pushes expected pixels into a queue; the monitor pops one per
// pix_stb and also checks cadence, line/frame periods and hold behaviour.
module tb_vga_timing_gen;

  // Tiny raster for instance C: hsync sx 8..10, vsync sy 6..7.
  localparam int C_HA = 6, C_HFP = 2, C_HS = 3, C_HBP = 2;
  localparam int C_VA = 4, C_VFP = 2, C_VS = 2, C_VBP = 3;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct packed {
    logic [1:0] k;
    obs_t       o;
  } ent_t;

  typedef struct packed {
    int div;
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int hpol, vpol;
  } tcfg_t;

  logic clk;
  logic rst_a, rst_b, rst_c;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .vid_o(ifa));

  vga_timing_gen #(.CLK_DIV(1), .H_SYNC_POL(1)) u_b (
    .clk(clk), .rst(rst_b), .vid_o(ifb)
  );

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(C_HA), .H_FP(C_HFP), .H_SYNC(C_HS), .H_BP(C_HBP),
    .V_ACTIVE(C_VA), .V_FP(C_VFP), .V_SYNC(C_VS), .V_BP(C_VBP)
  ) u_c (
    .clk(clk), .rst(rst_c), .vid_o(ifc)
  );

  obs_t cur0, cur1, cur2;
  assign cur0 = {ifa.sx, ifa.sy, ifa.de, ifa.vga_hsync, ifa.vga_vsync, ifa.line_start, ifa.frame_start};
  assign cur1 = {ifb.sx, ifb.sy, ifb.de, ifb.vga_hsync, ifb.vga_vsync, ifb.line_start, ifb.frame_start};
  assign cur2 = {ifc.sx, ifc.sy, ifc.de, ifc.vga_hsync, ifc.vga_vsync, ifc.line_start, ifc.frame_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];

  function automatic tcfg_t cfg(input int k);
    tcfg_t c;
    case (k)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      1:       c = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1, 0};
      default: c = '{2, C_HA, C_HFP, C_HS, C_HBP, C_VA, C_VFP, C_VS, C_VBP, 0, 0};
    endcase
    return c;
  endfunction

  function automatic int htot(input tcfg_t c);
    return c.ha + c.hfp + c.hsw + c.hbp;
  endfunction

  function automatic int vtot(input tcfg_t c);
    return c.va + c.vfp + c.vsw + c.vbp;
  endfunction

  // Expected outputs for the n-th pixel strobe after reset release.
  function automatic obs_t model(input int k, input int n);
    tcfg_t c  = cfg(k);
    int    x  = n % htot(c);
    int    y  = (n / htot(c)) % vtot(c);
    obs_t  o;
    o.sx = 10'(x);
    o.sy = 10'(y);
    o.de = (x < c.ha) && (y < c.va);
    o.hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? (c.hpol != 0) : (c.hpol == 0);
    o.vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? (c.vpol != 0) : (c.vpol == 0);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t rst_obs(input int k);
    tcfg_t c = cfg(k);
    obs_t  o;
    o.sx = 10'(htot(c) - 1);
    o.sy = 10'(vtot(c) - 1);
    o.de = 1'b0;
    o.hs = (c.hpol == 0);
    o.vs = (c.vpol == 0);
    o.ls = 1'b0;
    o.fs = 1'b0;
    return o;
  endfunction

  function automatic obs_t get_obs(input int k);
    case (k)
      0:       return cur0;
      1:       return cur1;
      default: return cur2;
    endcase
  endfunction

  function automatic logic get_stb(input int k);
    case (k)
      0:       return ifa.pix_stb;
      1:       return ifb.pix_stb;
      default: return ifc.pix_stb;
    endcase
  endfunction

  function automatic logic get_rst(input int k);
    case (k)
      0:       return rst_a;
      1:       return rst_b;
      default: return rst_c;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_rst(input int k, input logic v);
    case (k)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic chk_reset_state(input int k);
    chk($sformatf("reset_state%0d", k), 32'(get_obs(k)), 32'(rst_obs(k)));
    chk($sformatf("reset_pix_stb%0d", k), 32'(get_stb(k)), 32'd0);
  endtask

  // Release instance k, expect npx strobes, then reset it. With mid set, the
  // reset lands exactly on the edge that would have produced pixel npx.
  task automatic run_px(input int k, input int npx, input bit mid);
    tcfg_t c = cfg(k);
    for (int n = 0; n < npx; n++) q.push_back({2'(k), model(k, n)});
    @(posedge clk); #1;
    set_rst(k, 1'b0);
    repeat (mid ? c.div * (npx + 1) - 1 : c.div * npx) @(posedge clk);
    #1;
    set_rst(k, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk_reset_state(k);
    chk($sformatf("drain%0d", k), 32'(q.size()), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  // Monitor state
  int    gap  [3] = '{-1, -1, -1};
  int    lgap [3] = '{-1, -1, -1};
  int    fgap [3] = '{-1, -1, -1};
  obs_t  prev [3];
  obs_t  mc;
  logic  ms, mr;
  tcfg_t mcf;
  ent_t  me;

  // Scoreboard monitor: one pop per strobe plus cadence and hold checks.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mc  = get_obs(k);
      ms  = get_stb(k);
      mr  = get_rst(k);
      mcf = cfg(k);
      gap[k] = gap[k] + 1;
      if (lgap[k] >= 0) lgap[k] = lgap[k] + 1;
      if (fgap[k] >= 0) fgap[k] = fgap[k] + 1;
      if (ms) begin
        chk($sformatf("pix_period%0d", k), 32'(gap[k]), 32'(mcf.div));
        gap[k] = 0;
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_strobe%0d: got strobe at sx=%0d sy=%0d expected none", k, mc.sx, mc.sy);
        end else begin
          me = q.pop_front();
          chk($sformatf("strobe_inst%0d", k), 32'(k), 32'(me.k));
          chk($sformatf("pixel%0d sx=%0d sy=%0d", k, me.o.sx, me.o.sy), 32'(mc), 32'(me.o));
        end
        if (mc.ls) begin
          if (lgap[k] >= 0)
            chk($sformatf("line_period%0d", k), 32'(lgap[k]), 32'(htot(mcf) * mcf.div));
          lgap[k] = 0;
        end
        if (mc.fs) begin
          if (fgap[k] >= 0)
            chk($sformatf("frame_period%0d", k), 32'(fgap[k]), 32'(htot(mcf) * vtot(mcf) * mcf.div));
          fgap[k] = 0;
        end
      end else if (!mr) begin
        chk($sformatf("hold%0d", k), 32'(mc[24:2]), 32'(prev[k][24:2]));
        chk($sformatf("idle_strobes%0d", k), 32'({mc.ls, mc.fs}), 32'd0);
      end
      if (mr) begin
        gap[k]  = -1;
        lgap[k] = -1;
        fgap[k] = -1;
      end
      prev[k] = mc;
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset_state(k);

    // Defaults: two full lines plus part of a third (de/hsync windows, wrap).
    run_px(0, 1700, 1'b0);
    // CLK_DIV=1, positive hsync: strobe every clk, 800-clk lines.
    run_px(1, 1650, 1'b0);
    // Tiny raster: two whole frames plus a few pixels (vsync, sy wrap).
    run_px(2, 2 * 143 + 5, 1'b0);
    // Reset on the strobe edge that would show (sx=7, sy=5).
    run_px(2, 72, 1'b1);
    // Restart after mid-frame reset.
    run_px(2, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the screen/number_to_display path.
- Divides the system clock into a pixel strobe and produces the sx/sy coordinates those blocks consume.
- Produces the hsync/vsync pins, data-enable, and line/frame start strobes.
- Default timing: 640x480@60 from a 100 MHz clock; one 25 MHz pixel every 4 clocks.

Parameters:
- CLK_DIV, 4: system clocks per pixel; legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_SYNC_POL, 0: hsync level when asserted; 0 means active-low.
- V_SYNC_POL, 0: vsync level when asserted; 0 means active-low.
- Derived: H_TOTAL = sum of the H terms (800); V_TOTAL = sum of the V terms (525). Both must be ≤1024.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- sx  out  10  current pixel column, 0..H_TOTAL-1.
- sy  out  10  current line, 0..V_TOTAL-1.
- de  out  1  high when sx<H_ACTIVE and sy<V_ACTIVE.
- vga_hsync  out  1  horizontal sync, polarity per H_SYNC_POL.
- vga_vsync  out  1  vertical sync, polarity per V_SYNC_POL.
- pix_stb  out  1  one-clk pulse in the cycle new sx/sy first appear.
- line_start  out  1  one-clk pulse, coincident with pix_stb, when the new sx==0.
- frame_start  out  1  one-clk pulse, coincident with pix_stb, when new sx==0 and sy==0.

Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- All outputs are registered; there is no combinational path from the counters to any port.
- Reset (rst high at a clk edge):
  - div=0; sx=H_TOTAL-1 (799); sy=V_TOTAL-1 (524).
  - de=0; vga_hsync and vga_vsync at their deasserted levels (1 for the defaults).
  - pix_stb=0, line_start=0, frame_start=0.
  - Rationale: this positions the raster so the first advance lands on (0,0).
- Divider:
  - div counts 0..CLK_DIV-1.
  - At an edge with div==CLK_DIV-1: div goes to 0, the raster advances, and pix_stb is set to 1.
  - At every other edge: div increments and pix_stb is set to 0.
  - CLK_DIV=1: pix_stb is held high constantly after the first edge out of reset, and the raster advances every clk.
- Raster advance:
  - sx goes to sx+1.
  - If sx==H_TOTAL-1, sx goes to 0 and sy goes to sy+1.
  - If sy==V_TOTAL-1 on that same wrap, sy goes to 0.
  - No other wrap points exist; counters never exceed TOTAL-1.
- Registered decodes:
  - de, vga_hsync, vga_vsync, line_start and frame_start are computed from the next sx/sy values, so they stay aligned with the sx/sy on the ports.
- hsync asserted when H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 for the defaults.
- vsync asserted when V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- vsync changes only at line boundaries.
- Strobe clearing:
  - line_start and frame_start clear on the next clk, as pix_stb does.
  - Between strobes, sx, sy, de and both syncs hold their values.
- First advance latency: the first advance occurs at the CLK_DIV-th rising edge after rst deasserts. Its outputs are sx=0, sy=0, de=1, pix_stb=1, line_start=1, frame_start=1.
- Reset mid-frame: reset takes priority at any edge, including a strobe edge. The next state is exactly the reset state, with no partial-line output.
- Periods at defaults:
  - Line: 800 pixel strobes = 3200 clks.
  - Frame: 525 lines = 1,680,000 clks.
  - Exactly one frame_start per frame and one line_start per line.

Test Plan:
1. Reset values: hold rst for 3 clks → sx=799, sy=524, de=0, hsync=1, vsync=1, all strobes 0. Release rst → first pix_stb at edge 4 with sx=0, sy=0, de=1, line_start=1, frame_start=1.
2. Pixel cadence: run 40 clks → pix_stb high exactly 1 clk in every 4; sx advances by 1 per strobe; sx/sy stable between strobes.
3. Hsync/de window: run one line → de falls when sx goes 639→640; hsync goes 0 at sx=656 and 1 at sx=752; sx wraps 799→0 with sy+1 and line_start=1.
4. Frame wrap/vsync: run a full frame → vsync=0 only while sy∈{490,491}; sy wraps 524→0 with frame_start=1 after exactly 1,680,000 clks; de=0 for all sy≥480.
5. Mid-frame reset: assert rst on a pix_stb edge at (sx=300, sy=200) → next state is the exact reset state, with no strobe emitted. After release, timing restarts as in scenario 1.
6. Parameter variants:
   - CLK_DIV=1 with the defaults → pix_stb constantly high; line = 800 clks.
   - H_SYNC_POL=1 → hsync=1 only at sx 656..751; its reset value is 0.
